prng_word_gen: RTL and testbench

Pseudo-random word source that sits directly upstream of the 100-bit shift-accumulate stage and supplies its `r` operand. A 32-bit Galois LFSR is stepped once per cycle; successive LFSR states are packed into a 100-bit word. Words are offered over a valid/ready handshake, and a run delivers exactly `NWORDS` words per `start`.

---
 rtl/prng_word_gen_if.sv | 32 +++
 rtl/prng_word_gen.sv | 161 ++++++++++++++++
 tb/tb_prng_word_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/prng_word_gen_if.sv
// prng_word_gen_if
// Handshake/control bundle between a word consumer and prng_word_gen.
//   start, seed_ld, seed : run control and LFSR seeding (consumer -> generator)
//   r_ready              : consumer accepts r (consumer -> generator)
//   r, r_valid           : random word and its valid flag (generator -> consumer)
//   busy, done, word_cnt : run status (generator -> consumer)
// The master modport is the consumer side, the slave modport is the generator.
interface prng_word_gen_if #(
    parameter int W  = 32,
    parameter int RW = 100,
    parameter int CW = 7
);
    logic          start;
    logic          seed_ld;
    logic [W-1:0]  seed;
    logic          r_ready;
    logic [RW-1:0] r;
    logic          r_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_cnt;

    modport master (
        output start, seed_ld, seed, r_ready,
        input  r, r_valid, busy, done, word_cnt
    );

    modport slave (
        input  start, seed_ld, seed, r_ready,
        output r, r_valid, busy, done, word_cnt
    );
endinterface

// File: rtl/prng_word_gen.sv
// prng_word_gen
// Pseudo-random word source: a 32-bit right-shift Galois LFSR
// (x^32+x^22+x^2+x+1) steps once per FILL cycle; four successive states are
// packed into a 100-bit word and offered over valid/ready. Each start runs
// exactly NWORDS words, then pulses done.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : prng_word_gen_if slave (start/seed_ld/seed/r_ready in,
//          r/r_valid/busy/done/word_cnt out, all outputs registered)
module prng_word_gen #(
    parameter int          W      = 32,
    parameter int          RW     = 100,
    parameter int          CH     = 4,
    parameter int          NWORDS = 100,
    parameter int          CW     = 7,
    parameter logic [31:0] SEED   = 32'hACE1_2468
) (
    input  logic            clk,
    input  logic            rst,
    prng_word_gen_if.slave  bus
);
    localparam int          FW     = $clog2(CH);
    // Only the chunks that survive truncation to RW bits need storage: the
    // newest LFSR state is supplied combinationally, the older ones live here.
    localparam int          ASM_W  = RW - W;
    localparam logic [W-1:0] POLY  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_VALID = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    lfsr_r;
    logic [W-1:0]    lfsr_step_s;
    logic [ASM_W-1:0] asm_r;
    logic [RW-1:0]   asm_next_s;
    logic [FW-1:0]   fill_cnt_r;
    logic [CW-1:0]   word_cnt_r;
    logic [RW-1:0]   r_r;
    logic            r_valid_r;
    logic            busy_r;
    logic            done_r;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur);
        logic [W-1:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ POLY;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    // Next LFSR state and the word it would complete.
    always_comb begin
        lfsr_step_s = lfsr_step(lfsr_r);
        asm_next_s  = {asm_r, lfsr_step_s};
    end

    // Run sequencing: IDLE -> FILL x CH -> VALID -> ... -> DONE -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_cnt_r == FW'(CH - 1)) begin
                    state_nxt_s = ST_VALID;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_VALID: begin
                if (bus.r_ready) begin
                    if (word_cnt_r == CW'(NWORDS - 1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_VALID;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= SEED;
            asm_r      <= {ASM_W{1'b0}};
            fill_cnt_r <= {FW{1'b0}};
            word_cnt_r <= {CW{1'b0}};
            r_r        <= {RW{1'b0}};
            r_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            r_valid_r <= (state_nxt_s == ST_VALID);
            case (state_r)
                ST_IDLE: begin
                    // A zero seed would lock the LFSR, so substitute SEED.
                    if (bus.seed_ld) begin
                        lfsr_r <= (bus.seed == {W{1'b0}}) ? SEED : bus.seed;
                    end
                    if (bus.start) begin
                        word_cnt_r <= {CW{1'b0}};
                        fill_cnt_r <= {FW{1'b0}};
                    end
                end
                ST_FILL: begin
                    lfsr_r     <= lfsr_step_s;
                    asm_r      <= asm_next_s[ASM_W-1:0];
                    fill_cnt_r <= fill_cnt_r + FW'(1);
                    if (fill_cnt_r == FW'(CH - 1)) begin
                        r_r <= asm_next_s;
                    end
                end
                ST_VALID: begin
                    if (bus.r_ready) begin
                        word_cnt_r <= word_cnt_r + CW'(1);
                        fill_cnt_r <= {FW{1'b0}};
                    end
                end
                ST_DONE: begin
                    fill_cnt_r <= {FW{1'b0}};
                end
                default: begin
                    fill_cnt_r <= {FW{1'b0}};
                end
            endcase
        end
    end

    assign bus.r        = r_r;
    assign bus.r_valid  = r_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.word_cnt = word_cnt_r;

endmodule

// File: tb/tb_prng_word_gen.sv
// tb_prng_word_gen
// Directed sequence with randomized r_ready and busy-time meddling, checked
// against a word-level LFSR reference model held in the bench.
module tb_prng_word_gen;
    localparam int          NW   = 100;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    logic [31:0] m_lfsr;

    prng_word_gen_if #(.W(32), .RW(100), .CW(7)) bus ();

    prng_word_gen #(
        .W(32), .RW(100), .CH(4), .NWORDS(NW), .CW(7), .SEED(SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: right-shift Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] m_step(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        else      return x >> 1;
    endfunction

    // Four successive states concatenated, oldest first, truncated to 100 bits.
    task automatic m_word(output logic [99:0] w);
        logic [127:0] acc;
        acc = 128'd0;
        for (int i = 0; i < 4; i++) begin
            m_lfsr = m_step(m_lfsr);
            acc = (acc << 32) | {96'd0, m_lfsr};
        end
        w = acc[99:0];
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_r"},        bus.r,        128'd0);
        chk({tag, "_r_valid"},  bus.r_valid,  128'd0);
        chk({tag, "_busy"},     bus.busy,     128'd0);
        chk({tag, "_done"},     bus.done,     128'd0);
        chk({tag, "_word_cnt"}, bus.word_cnt, 128'd0);
        chk({tag, "_lfsr"},     dut.lfsr_r,   {96'd0, SEED});
    endtask

    // Called at the negedge right after the start edge (or after a handshake).
    // Steps one cycle per iteration, checking every word against the model.
    // Returns early (r_ready low, word still in VALID) once hs reaches stop_hs.
    task automatic run_loop(input bit rnd_ready, input bit meddle, input int hs_init,
                            input int stop_hs, output int done_edge);
        logic [99:0] w_exp;
        bit pending;
        bit fin;
        int hs;
        hs = hs_init; pending = 1'b0; fin = 1'b0; done_edge = -1; w_exp = 100'd0;
        for (int e = 0; e < 4000 && !fin; e++) begin
            if (done_edge >= 0) begin
                chk("done_single", bus.done, 128'd0);
                chk("busy_after",  bus.busy, 128'd0);
                chk("wc_hold",     bus.word_cnt, NW);
                fin = 1'b1;
            end else if (hs == NW) begin
                chk("done_pulse", bus.done, 128'd1);
                chk("busy_done",  bus.busy, 128'd1);
                chk("wc_final",   bus.word_cnt, NW);
                done_edge = e;
            end else begin
                chk("busy_run", bus.busy, 128'd1);
                chk("done_run", bus.done, 128'd0);
                chk("wc_run",   bus.word_cnt, hs);
                if (bus.r_valid) begin
                    if (!pending) begin
                        m_word(w_exp);
                        pending = 1'b1;
                    end
                    chk("r_word", bus.r, w_exp);
                    if (hs == stop_hs) begin
                        bus.r_ready = 1'b0;
                        fin = 1'b1;
                    end else begin
                        bus.r_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                        if (bus.r_ready) begin
                            hs++;
                            pending = 1'b0;
                        end
                    end
                end else begin
                    bus.r_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            if (meddle && e == 7) begin
                bus.start = 1'b1; bus.seed_ld = 1'b1; bus.seed = $urandom | 32'd1;
            end else begin
                bus.start = 1'b0; bus.seed_ld = 1'b0;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) chk("run_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        logic [99:0] w;
        int de;
        n_checks = 0; n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.seed_ld = 1'b0; bus.seed = 32'd0; bus.r_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_reset_outputs("idle");
        end

        // Seed 1 and start together; r_valid rises on the 4th edge after start.
        bus.seed_ld = 1'b1; bus.seed = 32'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.seed_ld = 1'b0; bus.start = 1'b0;
        m_lfsr = 32'd1;
        chk("busy_start", bus.busy, 128'd1);
        chk("valid_e0",   bus.r_valid, 128'd0);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("valid_rise", bus.r_valid, (e == 4) ? 128'd1 : 128'd0);
        end
        m_word(w);
        chk("first_r_model", bus.r, w);
        w = 100'h3_C030_0002_6018_0001_B02C_0003;
        chk("first_r_const", bus.r, w);

        // Backpressure: 20 cycles with r_ready low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_r",     bus.r, w);
            chk("bp_valid", bus.r_valid, 128'd1);
            chk("bp_wc",    bus.word_cnt, 128'd0);
            chk("bp_lfsr",  dut.lfsr_r, 128'hB02C_0003);
        end
        bus.r_ready = 1'b1;
        @(negedge clk);
        chk("hs1_wc",    bus.word_cnt, 128'd1);
        chk("hs1_valid", bus.r_valid, 128'd0);
        run_loop(1'b1, 1'b0, 1, -1, de);

        // Zero seed loads SEED; full run with r_ready=1 and busy-time meddling.
        bus.seed_ld = 1'b1; bus.seed = 32'd0;
        @(negedge clk);
        bus.seed_ld = 1'b0;
        chk("seed0_lfsr", dut.lfsr_r, {96'd0, SEED});
        chk("wc_idle_hold", bus.word_cnt, NW);
        m_lfsr = SEED;
        bus.start = 1'b1; bus.r_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("wc_cleared", bus.word_cnt, 128'd0);
        run_loop(1'b0, 1'b1, 0, -1, de);
        chk("done_edge", de, 128'd500);

        // Reset while word 37 sits in VALID; no done, everything back to reset.
        bus.start = 1'b1; bus.r_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_loop(1'b1, 1'b0, 0, 36, de);
        chk("w37_valid", bus.r_valid, 128'd1);
        chk("w37_wc",    bus.word_cnt, 128'd36);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_nodone", bus.done, 128'd0);
        m_lfsr = SEED;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_loop(1'b0, 1'b0, 0, -1, de);
        chk("done_edge2", de, 128'd500);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
